// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Brief    : instruction FIFO feeding a registered vector-control decoder;
//            define CTRL_HAZARD_EN to insert a load-use bubble.
// Revision : 1.0
// ============================================================================
module control_pipe #(
    parameter int DEPTH = 4,
    parameter int BYTES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               aluop,
    output logic [2:0]               ppp,
    output logic [1:0]               ww,
    output logic [2:0]               memop,
    output logic [2:0]               regop,
    output logic [4:0]               rrdaddra,
    output logic [4:0]               rrdaddrb,
    output logic [4:0]               rwraddrd,
    output logic [20:0]              maddr,
    output logic [BYTES-1:0]         wbyteen,
    output logic                     reginmuxop,
    output logic                     aluinmuxop,
    output logic [31:0]              immediate,
    output logic                     hazard,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(BYTES);

    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] c_lane_max = LW'(BYTES-1);

    localparam logic [2:0] c_regnop = 3'b000;
    localparam logic [2:0] c_rd0wr1 = 3'b001;
    localparam logic [2:0] c_rd1wr0 = 3'b010;
    localparam logic [2:0] c_rd1wr1 = 3'b011;
    localparam logic [2:0] c_rd2wr1 = 3'b100;
    localparam logic [2:0] c_memnop = 3'b000;
    localparam logic [2:0] c_memwld = 3'b001;
    localparam logic [2:0] c_memwst = 3'b010;
    localparam logic [5:0] c_alunop = 6'b000000;

    // Instruction bits are numbered MSB-first: field instr[a:b] lives at
    // w_head[31-a:31-b].
    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic [31:0]      w_head;
    logic             w_empty, w_push, w_pop, w_load, w_hazard;

    logic [5:0]       w_dec_aluop;
    logic [2:0]       w_dec_ppp, w_dec_memop, w_dec_regop;
    logic [1:0]       w_dec_ww;
    logic [4:0]       w_dec_rda, w_dec_rdb, w_dec_wrd;
    logic [20:0]      w_dec_maddr;
    logic [31:0]      w_dec_imm;
    logic             w_dec_reginmux, w_dec_aluinmux;
    logic [BYTES-1:0] w_byteen;
    logic [LW-1:0]    w_last;
    logic             w_ww_ok;
    logic             w_unused_bits;

    logic             r_valid, r_hazard;
    logic [5:0]       r_aluop;
    logic [2:0]       r_ppp, r_memop, r_regop;
    logic [1:0]       r_ww;
    logic [4:0]       r_rda, r_rdb, r_wrd;
    logic [20:0]      r_maddr;
    logic [31:0]      r_imm;
    logic             r_reginmux, r_aluinmux;
    logic [BYTES-1:0] r_wbyteen;

    assign w_empty       = (r_count == '0);
    assign in_ready      = (r_count < c_depth);
    assign w_head        = r_mem[r_rptr];
    assign w_unused_bits = ^w_head[31:30];
    assign w_load        = (!r_valid || out_ready) && !w_empty && !w_hazard;
    assign w_push        = in_valid && in_ready && !flush;
    assign w_pop         = w_load && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_dec_ppp      = w_head[10:8];
        w_dec_ww       = w_head[7:6];
        w_dec_maddr    = w_head[20:0];
        w_dec_wrd      = w_head[25:21];
        w_dec_rdb      = w_head[15:11];
        w_dec_rda      = w_head[20:16];
        w_dec_imm      = {w_head[15:11], 27'b0};
        w_dec_aluop    = c_alunop;
        w_dec_regop    = c_regnop;
        w_dec_memop    = c_memnop;
        w_dec_reginmux = 1'b0;
        w_dec_aluinmux = 1'b0;
        if (w_head[29]) begin
            w_dec_aluop    = w_head[5:0];
            w_dec_regop    = c_rd1wr1;
            w_dec_aluinmux = 1'b1;
        end else if (w_head[28]) begin
            if ({w_head[5:3], w_head[0]} == 4'b0101) begin
                w_dec_aluop    = {w_head[5:1], 1'b0};
                w_dec_regop    = c_rd1wr1;
                w_dec_aluinmux = 1'b1;
            end else if (w_head[5:0] == 6'b001000) begin
                w_dec_aluop    = w_head[5:0];
                w_dec_regop    = c_rd1wr1;
                w_dec_aluinmux = 1'b1;
            end else begin
                w_dec_aluop    = w_head[5:0];
                w_dec_regop    = c_rd2wr1;
            end
        end else if (w_head[27]) begin
            w_dec_regop = c_rd1wr0;
            w_dec_memop = c_memwst;
            w_dec_rda   = w_head[25:21];
        end else if (w_head[26]) begin
            w_dec_regop    = c_rd0wr1;
            w_dec_memop    = c_memwld;
            w_dec_reginmux = 1'b1;
        end
    end

    // Lane 0 is the most significant lane, so lane l drives bit BYTES-1-l.
    assign w_last  = c_lane_max >> w_dec_ww;
    assign w_ww_ok = (w_dec_ww != 2'b11);

    for (genvar l = 0; l < BYTES; l++) begin : g_lane
        logic [LW-1:0] w_elem;
        logic          w_sel;
        assign w_elem = LW'(l) >> w_dec_ww;
        always_comb begin
            w_sel = 1'b0;
            case (w_dec_ppp)
                3'b000:  w_sel = 1'b1;
                3'b001:  w_sel = (l < BYTES/2);
                3'b010:  w_sel = (l >= BYTES/2);
                3'b011:  w_sel = w_ww_ok && !w_elem[0];
                3'b100:  w_sel = w_ww_ok && w_elem[0];
                3'b101:  w_sel = w_ww_ok && (w_elem == '0);
                3'b110:  w_sel = w_ww_ok && (w_elem == w_last);
                default: w_sel = 1'b0;
            endcase
        end
        assign w_byteen[BYTES-1-l] = w_sel;
    end

`ifdef CTRL_HAZARD_EN
    logic w_use_a, w_use_b;
    assign w_use_a  = (w_dec_regop == c_rd1wr1) || (w_dec_regop == c_rd1wr0) ||
                      (w_dec_regop == c_rd2wr1);
    assign w_use_b  = (w_dec_regop == c_rd2wr1);
    assign w_hazard = r_valid && out_ready && !w_empty && (r_memop == c_memwld) &&
                      ((w_use_a && (w_dec_rda == r_wrd)) ||
                       (w_use_b && (w_dec_rdb == r_wrd)));
`else
    assign w_hazard = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_hazard   <= 1'b0;
            r_aluop    <= c_alunop;
            r_ppp      <= '0;
            r_ww       <= '0;
            r_memop    <= c_memnop;
            r_regop    <= c_regnop;
            r_rda      <= '0;
            r_rdb      <= '0;
            r_wrd      <= '0;
            r_maddr    <= '0;
            r_imm      <= '0;
            r_reginmux <= 1'b0;
            r_aluinmux <= 1'b0;
            r_wbyteen  <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_hazard <= 1'b0;
        end else if (w_hazard) begin
            r_valid  <= 1'b0;
            r_hazard <= 1'b1;
        end else begin
            r_hazard <= 1'b0;
            if (w_load) begin
                r_valid    <= 1'b1;
                r_aluop    <= w_dec_aluop;
                r_ppp      <= w_dec_ppp;
                r_ww       <= w_dec_ww;
                r_memop    <= w_dec_memop;
                r_regop    <= w_dec_regop;
                r_rda      <= w_dec_rda;
                r_rdb      <= w_dec_rdb;
                r_wrd      <= w_dec_wrd;
                r_maddr    <= w_dec_maddr;
                r_imm      <= w_dec_imm;
                r_reginmux <= w_dec_reginmux;
                r_aluinmux <= w_dec_aluinmux;
                r_wbyteen  <= w_byteen;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign hazard     = r_hazard;
    assign aluop      = r_aluop;
    assign ppp        = r_ppp;
    assign ww         = r_ww;
    assign memop      = r_memop;
    assign regop      = r_regop;
    assign rrdaddra   = r_rda;
    assign rrdaddrb   = r_rdb;
    assign rwraddrd   = r_wrd;
    assign maddr      = r_maddr;
    assign immediate  = r_imm;
    assign reginmuxop = r_reginmux;
    assign aluinmuxop = r_aluinmux;
    assign wbyteen    = r_wbyteen;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipe
// Brief    : directed self-checking bench for control_pipe (DEPTH=4, BYTES=16).
// Revision : 1.0
// ============================================================================
module tb_control_pipe;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, immediate;
    logic [5:0]  aluop;
    logic [2:0]  ppp, memop, regop, count;
    logic [1:0]  ww;
    logic [4:0]  rrdaddra, rrdaddrb, rwraddrd;
    logic [20:0] maddr;
    logic [15:0] wbyteen;
    logic        reginmuxop, aluinmuxop, hazard;

    int total  = 0;
    int passed = 0;
    logic [31:0] fill_w [6];

    control_pipe #(.DEPTH(4), .BYTES(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop(aluop), .ppp(ppp), .ww(ww), .memop(memop), .regop(regop),
        .rrdaddra(rrdaddra), .rrdaddrb(rrdaddrb), .rwraddrd(rwraddrd),
        .maddr(maddr), .wbyteen(wbyteen),
        .reginmuxop(reginmuxop), .aluinmuxop(aluinmuxop),
        .immediate(immediate), .hazard(hazard), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word);
        instr    = word;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // push, then one more edge so the word reaches the decode register
    task automatic send(input logic [31:0] word);
        push(word);
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        for (int i = 0; i < 6; i++) fill_w[i] = 32'h000A_0000 + 32'(i) * 32'h11;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_wbyteen", wbyteen, 16'h0000);
        chk("rst_regop", regop, 3'b000);
        chk("rst_memop", memop, 3'b000);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // fill with downstream stalled: one word sits in decode, four queue up
        for (int i = 0; i < 5; i++) push(fill_w[i]);
        instr = fill_w[5]; in_valid = 1'b1;
        tick(); tick();
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        chk("stall_maddr", maddr, 21'h0A0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_valid%0d", i), out_valid, 1);
            chk($sformatf("drain_maddr%0d", i), maddr, fill_w[i][20:0]);
            tick();
        end
        chk("drain_done_valid", out_valid, 0);
        chk("drain_done_count", count, 0);

        // alu shift-immediate
        send(32'h1000_2815);
        chk("shi_valid", out_valid, 1);
        chk("shi_aluop", aluop, 6'b010100);
        chk("shi_regop", regop, 3'b011);
        chk("shi_memop", memop, 3'b000);
        chk("shi_aluin", aluinmuxop, 1);
        chk("shi_regin", reginmuxop, 0);
        chk("shi_wbyteen", wbyteen, 16'hFFFF);
        chk("shi_imm", immediate, 32'h2800_0000);
        chk("shi_rdb", rrdaddrb, 5);
        chk("shi_maddr", maddr, 21'h002815);

        // wst, even 2-byte elements
        send(32'h08E0_0340);
        chk("wst_memop", memop, 3'b010);
        chk("wst_regop", regop, 3'b010);
        chk("wst_aluop", aluop, 0);
        chk("wst_rda", rrdaddra, 7);
        chk("wst_wrd", rwraddrd, 7);
        chk("wst_ppp", ppp, 3);
        chk("wst_ww", ww, 1);
        chk("wst_wbyteen", wbyteen, 16'hCCCC);

        // nop, last 4-byte element
        send(32'h0000_0680);
        chk("ll_wbyteen", wbyteen, 16'h000F);
        chk("ll_regop", regop, 0);
        chk("ll_memop", memop, 0);
        chk("ll_ww", ww, 2);

        // wmv wins over alu, upper half
        send(32'h3000_0133);
        chk("wmv_aluop", aluop, 6'b110011);
        chk("wmv_regop", regop, 3'b011);
        chk("wmv_aluin", aluinmuxop, 1);
        chk("wmv_regin", reginmuxop, 0);
        chk("wmv_wbyteen", wbyteen, 16'hFF00);

        // wnot, lower half
        send(32'h1000_0208);
        chk("wnot_aluop", aluop, 6'b001000);
        chk("wnot_regop", regop, 3'b011);
        chk("wnot_aluin", aluinmuxop, 1);
        chk("wnot_wbyteen", wbyteen, 16'h00FF);

        // generic alu, odd 4-byte elements
        send(32'h1000_0481);
        chk("alu_aluop", aluop, 6'b000001);
        chk("alu_regop", regop, 3'b100);
        chk("alu_aluin", aluinmuxop, 0);
        chk("alu_wbyteen", wbyteen, 16'h0F0F);

        // wld, element 0 of bytes
        send(32'h0460_0500);
        chk("wld_memop", memop, 3'b001);
        chk("wld_regop", regop, 3'b001);
        chk("wld_regin", reginmuxop, 1);
        chk("wld_aluop", aluop, 0);
        chk("wld_wrd", rwraddrd, 3);
        chk("wld_wbyteen", wbyteen, 16'h8000);

        send(32'h0000_03C0);
        chk("ww11_wbyteen", wbyteen, 16'h0000);
        send(32'h0000_0700);
        chk("ppp111_wbyteen", wbyteen, 16'h0000);

        // load to r3 followed by an alu op reading r3
        push(32'h0460_0000);
        push(32'h1003_0001);
        chk("hz_ld_valid", out_valid, 1);
        chk("hz_ld_memop", memop, 3'b001);
        tick();
`ifdef CTRL_HAZARD_EN
        chk("hz_bubble_hazard", hazard, 1);
        chk("hz_bubble_valid", out_valid, 0);
        chk("hz_bubble_count", count, 1);
        tick();
        chk("hz_after_hazard", hazard, 0);
        chk("hz_after_valid", out_valid, 1);
        chk("hz_after_aluop", aluop, 6'b000001);
        tick();
`else
        chk("hz_b2b_hazard", hazard, 0);
        chk("hz_b2b_valid", out_valid, 1);
        chk("hz_b2b_aluop", aluop, 6'b000001);
        chk("hz_b2b_regop", regop, 3'b100);
        tick();
`endif
        chk("hz_end_valid", out_valid, 0);

        // flush while full with a push and pop requested in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(fill_w[i]);
        chk("fl_pre_count", count, 4);
        instr = 32'h1234_5678; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_drop_valid", out_valid, 0);
        chk("fl_drop_count", count, 0);

        // asynchronous reset with three words queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h0000_0000);
        chk("mr_pre_count", count, 3);
        chk("mr_pre_wbyteen", wbyteen, 16'hFFFF);
        #3 reset = 1'b1;
        #1;
        chk("mr_count", count, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_wbyteen", wbyteen, 16'h0000);
        tick();
        reset = 1'b0;
        chk("mr_in_ready", in_ready, 1);
        tick();
        chk("mr_post_valid", out_valid, 0);
        chk("mr_post_count", count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
